// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: picks the highest-priority retire event (interrupt,
// exception or ERTN), pulses the CSR commit for one cycle, then holds WB
// while the fetch redirect is handshaken and the pipeline drains.
module exc_commit_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  wb_exc_vec,
  input  logic        wb_ertn,
  input  logic        has_int,
  input  logic [31:0] exc_entry,
  input  logic [31:0] exc_retaddr,
  input  logic        redirect_ready,
  output logic        wb_ready,
  output logic        csr_wb_exc,
  output logic [5:0]  csr_wb_ecode,
  output logic [8:0]  csr_wb_esubcode,
  output logic [31:0] csr_wb_pc,
  output logic        csr_ertn_flush,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REDIR, DRAIN} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  drain_cnt;
  logic [31:0] redir_target;
  logic        any_exc;
  logic        is_event;
  logic        take_exc;
  logic        take_ertn;
  logic [5:0]  ecode;

  // Event detection; gated by resetn so nothing commits while reset is held
  always_comb begin
    any_exc   = has_int | (|wb_exc_vec);
    is_event  = resetn & wb_valid & (state == IDLE) & (any_exc | wb_ertn);
    take_exc  = is_event & any_exc;
    take_ertn = is_event & ~any_exc;
  end

  // Fixed priority encoder: INT > ADEF > INE > SYS > BRK > ALE
  always_comb begin
    ecode = 6'h00;
    if (has_int)            ecode = 6'h00;
    else if (wb_exc_vec[0]) ecode = 6'h08;
    else if (wb_exc_vec[1]) ecode = 6'h0D;
    else if (wb_exc_vec[2]) ecode = 6'h0B;
    else if (wb_exc_vec[3]) ecode = 6'h0C;
    else if (wb_exc_vec[4]) ecode = 6'h09;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Redirect target capture on the event cycle and drain countdown
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drain_cnt    <= 4'd0;
      redir_target <= 32'd0;
    end else begin
      if (take_exc)
        redir_target <= exc_entry;
      else if (take_ertn)
        redir_target <= exc_retaddr;
      if (state == REDIR && redirect_ready)
        drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != 4'd0)
        drain_cnt <= drain_cnt - 4'd1;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (is_event) next_state = REDIR;
      REDIR:   if (redirect_ready) next_state = DRAIN;
      DRAIN:   if (drain_cnt == 4'd0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; commit pulses only ever come out of IDLE
  always_comb begin
    wb_ready        = 1'b0;
    csr_wb_exc      = 1'b0;
    csr_wb_ecode    = 6'h00;
    csr_wb_esubcode = 9'h000;
    csr_wb_pc       = 32'd0;
    csr_ertn_flush  = 1'b0;
    pipe_flush      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    case (state)
      IDLE: begin
        wb_ready       = 1'b1;
        csr_wb_exc     = take_exc;
        csr_ertn_flush = take_ertn;
        pipe_flush     = is_event;
        if (take_exc) begin
          csr_wb_ecode = ecode;
          csr_wb_pc    = wb_pc;
        end
      end
      REDIR: begin
        pipe_flush     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = redir_target;
      end
      DRAIN: begin
        pipe_flush = 1'b1;
      end
      default: begin
        wb_ready = 1'b1;
      end
    endcase
  end

endmodule
